// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline: operand forwarding, ALU and the
// EX/MEM pipeline register, plus a saturating counter of illegal ALU control codes.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [4:0]        mem_rd_addr,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_zero,
    output logic              mem_overflow,
    output logic [CNT_W-1:0]  alu_err_cnt
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              zero_q, zero_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0] op_a, fwd_b_val, op_b, sum, diff, alu_res;
    logic              legal, ovf, slt_lt;

    // EX/MEM forwarding taps the registered result, so a stalled slot forwards its held value.
    always_comb begin
        case (fwd_a)
            2'b10:   op_a = alu_result_q;
            2'b01:   op_a = wb_data;
            default: op_a = rs_data;
        endcase
        case (fwd_b)
            2'b10:   fwd_b_val = alu_result_q;
            2'b01:   fwd_b_val = wb_data;
            default: fwd_b_val = rt_data;
        endcase
        op_b   = alu_src ? imm : fwd_b_val;
        sum    = op_a + op_b;
        diff   = op_a - op_b;
        slt_lt = $signed(op_a) < $signed(op_b);
    end

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        legal   = 1'b1;
        case (alu_ctrl)
            ALU_ADD: begin
                alu_res = sum;
                ovf     = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                ovf     = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
            end
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_lt};
            default: legal = 1'b0;
        endcase
    end

    // Priority: flush > stall > bubble (ex_valid=0) > load.
    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_addr_d    = rd_addr_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        zero_d       = zero_q;
        overflow_d   = overflow_q;
        err_cnt_d    = err_cnt_q;
        if (flush || (!stall && !ex_valid)) begin
            valid_d      = 1'b0;
            alu_result_d = '0;
            store_data_d = '0;
            rd_addr_d    = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            zero_d       = 1'b0;
            overflow_d   = 1'b0;
        end else if (!stall) begin
            valid_d      = 1'b1;
            alu_result_d = alu_res;
            store_data_d = fwd_b_val;
            rd_addr_d    = rd_addr;
            reg_write_d  = reg_write & legal;
            mem_read_d   = mem_read & legal;
            mem_write_d  = mem_write & legal;
            zero_d       = (alu_res == '0);
            overflow_d   = ovf;
            if (!legal && (err_cnt_q != {CNT_W{1'b1}}))
                err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            zero_q       <= 1'b0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_addr_q    <= rd_addr_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            zero_q       <= zero_d;
            overflow_q   <= overflow_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_result = alu_result_q;
    assign mem_store_data = store_data_q;
    assign mem_rd_addr    = rd_addr_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_zero       = zero_q;
    assign mem_overflow   = overflow_q;
    assign alu_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed checks plus randomized traffic scored against a
// behavioural model of the EX/MEM register contents.
module tb_ex_stage;
    localparam int W = 83;

    logic        clk = 1'b0;
    logic        rst_n, ex_valid, alu_src, reg_write, mem_read, mem_write, stall, flush;
    logic [3:0]  alu_ctrl;
    logic [31:0] rs_data, rt_data, imm, wb_data;
    logic [4:0]  rd_addr;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_zero, mem_overflow;
    logic [31:0] mem_alu_result, mem_store_data;
    logic [4:0]  mem_rd_addr;
    logic [7:0]  alu_err_cnt;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // model of the EX/MEM register
    logic        m_valid, m_rw, m_mr, m_mw, m_z, m_ov;
    logic [31:0] m_res, m_sd;
    logic [4:0]  m_rd;
    int          m_cnt;

    ex_stage #(.DATA_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_src(alu_src),
        .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_zero(mem_zero), .mem_overflow(mem_overflow),
        .alu_err_cnt(alu_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'b10) return m_res;
        if (sel == 2'b01) return wb_data;
        return reg_val;
    endfunction

    // Advance the model by one edge from the current inputs, push its state, wait for the next negedge.
    task automatic tick();
        logic [31:0] a, fb, b;
        longint      sa, sb, s;
        logic        ok;
        logic [31:0] r;
        logic        ov;
        a  = pick(fwd_a, rs_data);
        fb = pick(fwd_b, rt_data);
        b  = alu_src ? imm : fb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ok = 1'b1;
        ov = 1'b0;
        r  = 32'd0;
        case (alu_ctrl)
            4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
        if (!rst_n) begin
            {m_valid, m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_z, m_ov} = '0;
            m_cnt = 0;
        end else if (flush || (!stall && !ex_valid)) begin
            {m_valid, m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_z, m_ov} = '0;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_res = r;
            m_sd = fb;
            m_rd = rd_addr;
            m_rw = reg_write && ok;
            m_mr = mem_read && ok;
            m_mw = mem_write && ok;
            m_z = (r == 32'd0);
            m_ov = ov;
            if (!ok && m_cnt < 255) m_cnt++;
        end
        exp_q.push_back({m_valid, m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_z, m_ov, m_cnt[7:0]});
        @(negedge clk);
    endtask

    // Monitor: every edge the EX/MEM register presents a new slot state.
    initial begin
        logic [W-1:0] act, exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act = {mem_valid, mem_alu_result, mem_store_data, mem_rd_addr, mem_reg_write,
                       mem_mem_read, mem_mem_write, mem_zero, mem_overflow, alu_err_cnt};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got v=%b res=%h sd=%h rd=%0d rw/mr/mw/z/ov=%b cnt=%0d expected v=%b res=%h sd=%h rd=%0d rw/mr/mw/z/ov=%b cnt=%0d",
                             $time, act[82], act[81:50], act[49:18], act[17:13], act[12:8], act[7:0],
                             exp_v[82], exp_v[81:50], exp_v[49:18], exp_v[17:13], exp_v[12:8], exp_v[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic idle();
        ex_valid = 0; alu_ctrl = 4'b0010; rs_data = 0; rt_data = 0; imm = 0; alu_src = 0;
        rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0; fwd_a = 0; fwd_b = 0;
        wb_data = 0; stall = 0; flush = 0;
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        idle();
        ex_valid = 1; alu_ctrl = c; rs_data = a; rt_data = b; rd_addr = 5'd1; reg_write = 1;
    endtask

    logic [3:0] legal_codes[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        m_cnt = 0;
        {m_valid, m_res, m_sd, m_rd, m_rw, m_mr, m_mw, m_z, m_ov} = '0;
        idle();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("reset_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset_result", mem_alu_result, 32'd0);
        chk("reset_cnt", {24'd0, alu_err_cnt}, 32'd0);

        op(4'b0010, 32'h7FFF_FFFF, 32'd1); tick();
        chk("add_ovf_res", mem_alu_result, 32'h8000_0000);
        chk("add_ovf_flag", {31'd0, mem_overflow}, 32'd1);
        chk("add_ovf_rw", {31'd0, mem_reg_write}, 32'd1);
        op(4'b0110, 32'd5, 32'd5); tick();
        chk("sub_zero_res", mem_alu_result, 32'd0);
        chk("sub_zero_flag", {31'd0, mem_zero}, 32'd1);
        op(4'b0111, 32'h8000_0000, 32'd1); tick();
        chk("slt_neg", mem_alu_result, 32'd1);
        op(4'b0001, 32'h0000_F0F0, 32'h0000_0F0F); tick();
        chk("or", mem_alu_result, 32'h0000_FFFF);

        op(4'b0010, 32'd3, 32'd4); tick();
        chk("fwd_first", mem_alu_result, 32'd7);
        op(4'b0010, 32'd0, 32'd0); fwd_a = 2'b10; alu_src = 1; imm = 32'd10; tick();
        chk("fwd_exmem", mem_alu_result, 32'd17);
        op(4'b0010, 32'd1, 32'd2); fwd_b = 2'b01; wb_data = 32'd100; tick();
        chk("fwd_wb_store", mem_store_data, 32'd100);
        chk("fwd_wb_res", mem_alu_result, 32'd101);

        op(4'b0010, 32'd1, 32'd2); tick();
        for (int i = 0; i < 3; i++) begin
            op(4'b1111, $urandom, $urandom); stall = 1; tick();
            chk("stall_hold", mem_alu_result, 32'd3);
        end
        chk("stall_cnt", {24'd0, alu_err_cnt}, 32'd0);
        op(4'b0010, 32'd1, 32'd2); stall = 1; flush = 1; tick();
        chk("flush_valid", {31'd0, mem_valid}, 32'd0);
        chk("flush_rw", {31'd0, mem_reg_write}, 32'd0);

        op(4'b1111, 32'd9, 32'd9); mem_write = 1; tick();
        chk("ill_valid", {31'd0, mem_valid}, 32'd1);
        chk("ill_ctrl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
        chk("ill_zero", {31'd0, mem_zero}, 32'd1);
        chk("ill_cnt", {24'd0, alu_err_cnt}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            op(4'($urandom_range(8, 15)), $urandom, $urandom); tick();
        end
        chk("cnt_sat", {24'd0, alu_err_cnt}, 32'd255);

        op(4'b1111, 32'd1, 32'd1); stall = 1; rst_n = 0; tick();
        rst_n = 1;
        chk("midrst_cnt", {24'd0, alu_err_cnt}, 32'd0);
        chk("midrst_valid", {31'd0, mem_valid}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            idle();
            ex_valid = ($urandom_range(0, 9) != 0);
            alu_ctrl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                   : legal_codes[$urandom_range(0, 4)];
            rs_data = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ 32'($urandom_range(0, 3)) : $urandom;
            rt_data = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            imm = $urandom; alu_src = 1'($urandom); rd_addr = 5'($urandom);
            reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            fwd_a = 2'($urandom); fwd_b = 2'($urandom); wb_data = $urandom;
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1;
        idle();
        tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
